// File: rtl/lsu_mem_master.sv
// Load/store unit memory master.
// Turns one core load/store request into single-word memory accesses:
//   - loads do one read;
//   - sub-word stores do a read, merge the new bytes, then write;
//   - word stores do one write.
// Misaligned requests and reads that wait too long on mem_busy_i get an error response.
//
// Handshake: a request is accepted on a rising clk_i edge where req_valid_i=1
// and req_ready_o=1 (IDLE only). resp_valid_o is a one-cycle strobe with no
// back-pressure.
module lsu_mem_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_wen_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_busy_i,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;    // store data, then the merged word
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [7:0]  wait_q, wait_d;

    logic        misaligned;
    logic [8:0]  wait_inc;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Alignment check on the incoming request fields.
    always_comb begin
        misaligned = 1'b0;
        case (req_size_i)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr_i[0];
            2'd2:    misaligned = (req_addr_i[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Little-endian lane extraction and extension, plus the sub-word store merge.
    always_comb begin
        lane_b   = mem_data_i[{addr_q[1:0], 3'b000} +: 8];
        lane_h   = mem_data_i[{addr_q[1], 4'b0000} +: 16];
        load_val = mem_data_i;
        merged   = mem_data_i;
        case (size_q)
            2'd0: begin
                load_val = {{24{~unsigned_q & lane_b[7]}}, lane_b};
                merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
            end
            2'd1: begin
                load_val = {{16{~unsigned_q & lane_h[15]}}, lane_h};
                merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
            end
            default: begin
                load_val = mem_data_i;
                merged   = mem_data_i;
            end
        endcase
    end

    // Next-state and registered-request logic.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        wait_d     = wait_q;
        wait_inc   = {1'b0, wait_q} + 9'd1;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    we_d       = req_we_i;
                    size_d     = req_size_i;
                    unsigned_d = req_unsigned_i;
                    addr_d     = req_addr_i;
                    data_d     = req_wdata_i;
                    rdata_d    = 32'd0;
                    err_d      = misaligned;
                    wait_d     = 8'd0;
                    if (misaligned)
                        state_d = S_RESP;
                    else if (req_we_i && (req_size_i == 2'd2))
                        state_d = S_WRITE;
                    else
                        state_d = S_READ;
                end
            end
            S_READ: begin
                if (!mem_busy_i) begin
                    if (!we_q) begin
                        rdata_d = load_val;
                        state_d = S_RESP;
                    end else begin
                        data_d  = merged;
                        state_d = S_WRITE;
                    end
                end else begin
                    wait_d = wait_inc[7:0];
                    if (wait_inc == TIMEOUT_W) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_WRITE: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    // State and request registers; reset clears everything at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
            wait_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            wait_q     <= wait_d;
        end
    end

    // Outputs decode from state.
    // Every output is gated with rst_i, so a write in progress is dropped
    // before the next edge.
    always_comb begin
        req_ready_o  = ~rst_i & (state_q == S_IDLE);
        mem_wen_o    = ~rst_i & (state_q == S_WRITE);
        mem_addr_o   = (~rst_i & ((state_q == S_READ) | (state_q == S_WRITE)))
                       ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_data_o   = (~rst_i & (state_q == S_WRITE)) ? data_q : 32'd0;
        resp_valid_o = ~rst_i & (state_q == S_RESP);
        resp_err_o   = resp_valid_o & err_q;
        resp_rdata_o = resp_valid_o ? rdata_q : 32'd0;
        dbg_state_o  = state_q;
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Testbench for lsu_mem_master.
// The bench has four parts:
//   - a word memory model;
//   - directed and random requests;
//   - a reference model that predicts each response from the access rules;
//   - a monitor that checks each response strobe against the queued expectation.
module tb_lsu_mem_master;

  localparam int TO = 16;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    int          lat;   // 0 = latency not checked
    int          acc;   // cycle number of the accepting edge
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_wen_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_busy_i;
  logic [1:0]  dbg_state_o;

  logic [31:0] tb_mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] garbage;
  exp_t        exp_q [$];
  exp_t        e_m;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int issued = 0;
  int resp_cnt = 0;

  lsu_mem_master #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o), .mem_wen_o(mem_wen_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_busy_i(mem_busy_i), .dbg_state_o(dbg_state_o)
  );

  // Clock and cycle counter.
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory model: read data is garbage while busy, writes commit on the edge.
  assign mem_data_i = mem_busy_i ? garbage : tb_mem[mem_addr_o[9:2]];
  always @(posedge clk_i) if (mem_wen_o) tb_mem[mem_addr_o[9:2]] <= mem_data_o;
  always @(negedge clk_i) garbage <= $urandom;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: predicts one response and updates ref_mem.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int busy_n, output exp_t e);
    logic        mis;
    logic [31:0] w, v, mask;
    int          sh;
    mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    w   = ref_mem[addr[9:2]];
    e   = '0;
    if (mis) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (we && size == 2'd2) begin
      ref_mem[addr[9:2]] = wdata;
      e.lat = 2;
    end else if (busy_n >= TO) begin
      e.err = 1'b1;
      e.lat = 0;
    end else if (!we) begin
      if (size == 2'd0) begin
        sh = int'(addr[1:0]) * 8;
        v = (w >> sh) & 32'hFF;
        if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
        sh = int'(addr[1]) * 16;
        v = (w >> sh) & 32'hFFFF;
        if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end else begin
        v = w;
      end
      e.rdata = v;
      e.lat = 2 + busy_n;
    end else begin
      if (size == 2'd0) begin
        sh = int'(addr[1:0]) * 8;
        mask = 32'hFF << sh;
        ref_mem[addr[9:2]] = (w & ~mask) | ((wdata & 32'hFF) << sh);
      end else begin
        sh = int'(addr[1]) * 16;
        mask = 32'hFFFF << sh;
        ref_mem[addr[9:2]] = (w & ~mask) | ((wdata & 32'hFFFF) << sh);
      end
      e.lat = 3 + busy_n;
    end
  endtask

  // Driver: issue one request, hold busy for busy_n READ cycles, await the response.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int busy_n);
    exp_t e;
    int   k;
    @(negedge clk_i);
    k = 0;
    while (!req_ready_o && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    if (!req_ready_o) begin
      tests++;
      fails++;
      $display("FAIL ready_wait: req_ready_o stayed 0, expected 1");
      return;
    end
    req_valid_i = 1'b1;
    req_we_i = we;
    req_size_i = size;
    req_unsigned_i = uns;
    req_addr_i = addr;
    req_wdata_i = wdata;
    mem_busy_i = 1'b0;
    model(we, size, uns, addr, wdata, busy_n, e);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    issued++;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_we_i = 1'($urandom);
    req_addr_i = $urandom;
    req_wdata_i = $urandom;
    for (int i = 0; i < busy_n; i++) begin
      mem_busy_i = 1'b1;
      @(negedge clk_i);
    end
    mem_busy_i = 1'b0;
    k = 0;
    while (resp_cnt < issued && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    if (resp_cnt < issued) begin
      tests++;
      fails++;
      $display("FAIL resp_wait: no response to request at %h", addr);
      exp_q.delete();
      resp_cnt = issued;
    end
  endtask

  // Monitor: pop and compare on every response strobe, check idle values otherwise.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (resp_valid_o) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got resp_valid_o=1, expected no response");
        end else begin
          e_m = exp_q.pop_front();
          chk("resp_err", 32'(resp_err_o), 32'(e_m.err));
          chk("resp_rdata", resp_rdata_o, e_m.rdata);
          if (e_m.lat != 0) chk("resp_latency", 32'(cyc - e_m.acc + 1), 32'(e_m.lat));
        end
        chk("mem_idle_in_resp", {mem_wen_o, mem_addr_o[30:0]} | mem_data_o, 32'd0);
      end else begin
        chk("resp_idle", {resp_err_o, resp_rdata_o[30:0]}, 32'd0);
      end
      if (req_ready_o) chk("mem_idle_in_idle", {mem_wen_o, mem_addr_o[30:0]} | mem_data_o, 32'd0);
      chk("mem_addr_aligned", 32'(mem_addr_o[1:0]), 32'd0);
    end
  end

  initial begin
    logic [31:0] a, prev;
    logic [1:0]  sz;
    int          b;
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    req_we_i = 1'b0;
    req_size_i = 2'd0;
    req_unsigned_i = 1'b0;
    req_addr_i = 32'd0;
    req_wdata_i = 32'd0;
    mem_busy_i = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[8'h40] = 32'h8899_AABB; ref_mem[8'h40] = 32'h8899_AABB;
    tb_mem[8'h80] = 32'h1122_3344; ref_mem[8'h80] = 32'h1122_3344;

    // Reset behaviour.
    repeat (3) @(negedge clk_i);
    chk("reset_ready", 32'(req_ready_o), 32'd0);
    chk("reset_outputs", {resp_valid_o, resp_err_o, mem_wen_o, 29'd0} | resp_rdata_o | mem_addr_o | mem_data_o, 32'd0);
    rst_i = 1'b0;
    #1 chk("ready_after_reset", 32'(req_ready_o), 32'd1);

    // Directed cases.
    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 0);           // lb  -> FFFFFF88
    do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 0);           // lbu -> 00000088
    do_req(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_BEEF, 0);   // sh merge
    chk("sh_merge_word", tb_mem[8'h80], 32'hBEEF_3344);
    do_req(1'b0, 2'd2, 1'b0, 32'h101, 32'd0, 0);           // misaligned lw
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 3);           // lw with busy 3
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 40);          // lw timeout
    do_req(1'b1, 2'd0, 1'b0, 32'h201, 32'h55, 40);         // sb timeout, no write
    chk("no_write_on_timeout", tb_mem[8'h80], 32'hBEEF_3344);
    do_req(1'b1, 2'd2, 1'b0, 32'h204, 32'hCAFE_F00D, 5);   // sw ignores busy

    // Reset in the middle of a word store.
    prev = tb_mem[8'h10];
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd2;
    req_addr_i = 32'h40; req_wdata_i = 32'hDEAD_BEEF;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("write_started", 32'(mem_wen_o), 32'd1);
    rst_i = 1'b1;
    #1 chk("wen_dropped_by_reset", 32'(mem_wen_o), 32'd0);
    @(negedge clk_i);
    chk("ready_in_reset", 32'(req_ready_o), 32'd0);
    rst_i = 1'b0;
    #1 chk("ready_after_abort", 32'(req_ready_o), 32'd1);
    chk("aborted_write_absent", tb_mem[8'h10], prev);

    // Random traffic.
    for (int n = 0; n < 200; n++) begin
      sz = 2'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      b = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, b);
    end

    repeat (3) @(negedge clk_i);
    for (int i = 0; i < 256; i++) chk("final_mem", tb_mem[i], ref_mem[i]);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
